display_timings: RTL
====================

// Module: display_timings
// PURPOSE
//  Raster timing generator for the 640x480@60 display path; sits directly upstream of game_loop.
//  Produces the pixel coordinates sx/sy, the frame tick that paces game logic, and the sync and
//  data-enable strobes consumed by the video output stage. All outputs are registered and
//  mutually aligned: on any cycle they all describe the same pixel.
// PARAMETERS
//  CORDW   10  coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
//  H_RES   640 active pixels per line
//  H_FP    16  horizontal front porch, in pixels
//  H_SYNC  96  hsync width, in pixels
//  H_BP    48  horizontal back porch (H_TOTAL = 800)
//  V_RES   480 active lines per frame
//  V_FP    10  vertical front porch, in lines
//  V_SYNC  2   vsync width, in lines
//  V_BP    33  vertical back porch (V_TOTAL = 525)
//  H_POL   0   hsync active level (0 = active-low)
//  V_POL   0   vsync active level (0 = active-low)
// PORTS
//  clk    in   1      system clock
//  rst_n  in   1      asynchronous reset, active-low
//  pix_en in   1      pixel advance enable; may be tied high or pulsed at a sub-rate
//  sx     out  CORDW  current horizontal position, 0..H_TOTAL-1
//  sy     out  CORDW  current vertical position, 0..V_TOTAL-1
//  hsync  out  1      horizontal sync, level set by H_POL
//  vsync  out  1      vertical sync, level set by V_POL
//  de     out  1      data enable; high when sx<H_RES and sy<V_RES
//  frame  out  1      one-clk pulse at start of vertical blank
//  line   out  1      one-clk pulse at start of each line
// BEHAVIOUR
//  Reset (asynchronous, while rst_n=0):
//  - sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, frame=0, line=0.
//  - hsync=~H_POL, vsync=~V_POL.
//  - This is the final pixel of a frame, so the first pix_en after release moves to (0,0).
//  Advance (rising clk edge with pix_en=1):
//  - If sx==H_TOTAL-1: sx<=0 and sy<=sy+1, or sy<=0 when sy==V_TOTAL-1.
//  - Otherwise sx<=sx+1 and sy holds.
//  - pix_en=0: sx, sy, hsync, vsync and de hold their values.
//  Decode: hsync, vsync and de are registered from the next coordinate values, so they change
//  on the same edge as sx/sy. There is no skew and no extra latency.
//  - hsync active when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC, i.e. 656..751.
//  - vsync active when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, i.e. 490..491.
//  Pulses: frame and line are high for exactly one clk cycle, on the edge that advances into
//  the qualifying position. They are low on every other cycle, including while pix_en=0.
//  - line: the advance lands on sx==0 (any sy).
//  - frame: the advance lands on sx==0 and sy==V_RES.
//  - Both pulses fire together at (0,V_RES).
//  Widths: all comparisons are unsigned, CORDW-bit. Counters never exceed their TOTAL-1 value.
//  Reset mid-frame: outputs take their reset values immediately, with no partial pulse.
//  Timing restarts cleanly after release.
// TESTING
//  1. Reset, then pix_en=1 held -> edge 1: sx=0, sy=0, de=1, line=1.
//     Edge 801: sx=0, sy=1, line=1.
//  2. Over one line -> hsync low for exactly 96 edges (sx 656..751). de high for 640 edges.
//  3. Full frame -> vsync low for 1600 edges (sy 490..491). frame=1 exactly once per 420000
//     edges, at sx=0, sy=480, de=0. sy wraps 524->0.
//  4. pix_en high 1 cycle in 4 -> sx steps every 4 clks. line and frame are one-clk wide, not 4.
//  5. rst_n pulled low at (300,200) -> same cycle: sx=799, sy=524, de=0, hsync=vsync=1.
//     After release, the first pix_en gives (0,0) with line=1.
//  6. H_POL=1, V_POL=1 override -> syncs are high only inside their windows; reset value is 0.

Source files
------------

// File: rtl/display_timings.sv
// ---------------------------------------------------------------------------
// display_timings
//   Raster timing generator (default 640x480@60). Walks a pixel position
//   (sx, sy) across the full raster, including blanking. It decodes the
//   horizontal and vertical sync, data enable, and one-clock line/frame
//   pulses from that position. Every output is registered from the *next*
//   coordinate, so all outputs describe the same pixel on every cycle.
//
// Ports
//   clk    in   1      system clock
//   rst_n  in   1      asynchronous reset, active-low
//   pix_en in   1      pixel advance enable (tied high or sub-rate strobe)
//   sx     out  CORDW  horizontal position, 0..H_TOTAL-1
//   sy     out  CORDW  vertical position, 0..V_TOTAL-1
//   hsync  out  1      horizontal sync, active level H_POL
//   vsync  out  1      vertical sync, active level V_POL
//   de     out  1      data enable, high inside the active area
//   frame  out  1      one-clk pulse on entering (0, V_RES)
//   line   out  1      one-clk pulse on entering sx == 0
// ---------------------------------------------------------------------------
module display_timings #(
    parameter int unsigned CORDW  = 10,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter logic        H_POL  = 1'b0,
    parameter logic        V_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line
);

    localparam int unsigned H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_HS_BEG = H_RES + H_FP;
    localparam int unsigned H_HS_END = H_RES + H_FP + H_SYNC;
    localparam int unsigned V_VS_BEG = V_RES + V_FP;
    localparam int unsigned V_VS_END = V_RES + V_FP + V_SYNC;

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_frame;
    logic             r_line;

    logic [CORDW-1:0] w_sx_nxt;
    logic [CORDW-1:0] w_sy_nxt;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_de_nxt;
    logic             w_line_nxt;
    logic             w_frame_nxt;

    // Next raster position: wrap x at end of line, then y at end of frame
    always_comb begin
        w_sx_nxt = r_sx + CORDW'(1);
        w_sy_nxt = r_sy;
        if (r_sx == CORDW'(H_TOTAL - 1)) begin
            w_sx_nxt = '0;
            if (r_sy == CORDW'(V_TOTAL - 1)) begin
                w_sy_nxt = '0;
            end else begin
                w_sy_nxt = r_sy + CORDW'(1);
            end
        end
    end

    // Decode strobes from the next position so they land with sx/sy
    always_comb begin
        w_hs_act    = (w_sx_nxt >= CORDW'(H_HS_BEG)) && (w_sx_nxt < CORDW'(H_HS_END));
        w_vs_act    = (w_sy_nxt >= CORDW'(V_VS_BEG)) && (w_sy_nxt < CORDW'(V_VS_END));
        w_de_nxt    = (w_sx_nxt < CORDW'(H_RES)) && (w_sy_nxt < CORDW'(V_RES));
        w_line_nxt  = (w_sx_nxt == '0);
        w_frame_nxt = (w_sx_nxt == '0) && (w_sy_nxt == CORDW'(V_RES));
    end

    // Reset parks on the last pixel so the first advance enters (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx    <= CORDW'(H_TOTAL - 1);
            r_sy    <= CORDW'(V_TOTAL - 1);
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else if (pix_en) begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_hsync <= w_hs_act ? H_POL : ~H_POL;
            r_vsync <= w_vs_act ? V_POL : ~V_POL;
            r_de    <= w_de_nxt;
            r_frame <= w_frame_nxt;
            r_line  <= w_line_nxt;
        end else begin
            // Pulses must not stretch across stalled cycles
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign frame = r_frame;
    assign line  = r_line;

endmodule
